trap_controller: RTL and testbench
==================================

# trap_controller

Execute-stage trap responder: consumes the exception/xRET indications the execute stage raises and turns them into machine-mode trap entry and return. Holds the machine trap CSRs (mstatus, mtvec, mepc, mcause) and the current privilege level. Issues a single PC redirect plus a pipeline flush to fetch with a valid/ready handshake, and stalls the pipeline while a redirect is pending. Sits beside the execute stage; its outputs feed the PC-select mux and the hazard unit.

## Interface
- RESET_TVEC, 32'h0000_0000, reset value of mtvec
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- exceptionE  in  1  execute-stage instruction raised an exception
- exceptionCodeE  in  8  cause code for exceptionE
- iretE  in  1  execute-stage instruction is an xRET
- retKindE  in  2  xRET kind: 00 uret, 01 sret, 11 mret
- pcE  in  32  PC of the execute-stage instruction
- irqExt  in  1  level-sensitive external interrupt request
- csrWe  in  1  CSR write strobe
- csrAddr  in  12  CSR address
- csrWData  in  32  CSR write data
- csrRData  out  32  CSR read data, combinational
- redirectValid  out  1  redirect request to fetch
- redirectReady  in  1  fetch accepts redirect
- redirectPC  out  32  redirect target
- flush  out  1  flush fetch/decode/execute
- busy  out  1  stall request to hazard unit
- privMode  out  2  current privilege (11 M, 00 U)

## Operation
- States: IDLE, REDIRECT.
- In IDLE, one event is selected per cycle by priority: exception > xRET > interrupt.
- Exception (exceptionE=1): mepc<=pcE with bits[1:0] forced to 0. mcause<={1'b0, 23'b0, exceptionCodeE}. MPIE<=MIE, MIE<=0, MPP<=privMode, privMode<=11. Target = {mtvec[31:2],2'b00}. Go to REDIRECT.
- mret (iretE=1, retKindE=11, no exception): privMode<=MPP, MIE<=MPIE, MPIE<=1, MPP<=00. Target = mepc. Go to REDIRECT.
- uret/sret (iretE=1, retKindE≠11): not supported. Treated as an exception with code 2 (illegal instruction), same effects as above.
- Interrupt (irqExt=1 and MIE=1, no exception or xRET): mepc<=pcE; mcause<=32'h8000_000B; trap-entry effects as for exception.
  - mtvec[0]=0: target = base.
  - mtvec[0]=1: target = base + 4*11 = base + 0x2C.
- In REDIRECT, all event inputs are ignored. Go to IDLE on redirectReady=1.
- CSR map:
  - 0x300 mstatus: MIE bit 3, MPIE bit 7, MPP bits 12:11; other bits read 0.
  - 0x305 mtvec.
  - 0x341 mepc: bits[1:0] written as 0.
  - 0x342 mcause.
  - Any other address reads 0, writes ignored.
- A CSR write in the same cycle as a taken trap/mret is dropped. CSR writes are dropped while in REDIRECT.
- MPP written with 01 or 10 is stored as 00.

## Timing
- Reset (rst_n=0 at an edge):
  - State, privilege, flags: state=IDLE, privMode=11, MIE=0, MPIE=0, MPP=00.
  - CSRs: mepc=0, mcause=0, mtvec=RESET_TVEC.
  - Outputs: redirectValid=0, flush=0, busy=0, redirectPC=0.
  - Reset mid-REDIRECT aborts the redirect the same edge.
- An event sampled in cycle N updates CSRs at the end of N.
- In cycle N+1: redirectValid=1, flush=1, busy=1, and redirectPC is registered. These are held stable until the cycle in which redirectReady=1. All three drop the following cycle.
- redirectReady in the same cycle redirectValid rises completes the handshake in one cycle.
- busy=1 only in REDIRECT. The event cycle itself is not stalled.
- Back-to-back: an event may be accepted in the first IDLE cycle after REDIRECT.
- csrRData reflects register state before the current edge (no write-through bypass).

## Test plan
- Reset with RESET_TVEC=0x100, then exceptionE=1, code=0x02, pcE=0x2004 -> next cycle redirectValid=1, redirectPC=0x100, flush=1, mcause=0x2, mepc=0x2004, privMode=11.
- Write mstatus MIE=1, mtvec=0x401, hold irqExt=1 with pcE=0x3000 -> redirectPC=0x42C, mcause=0x8000000B, MIE=0, MPIE=1; irqExt alone after that is ignored because MIE=0.
- Trap from privMode=00 then mret -> redirectPC=mepc, privMode=00, MIE restored from MPIE, MPIE=1, MPP=00.
- iretE=1, retKindE=01, pcE=0x500 -> illegal-instruction trap: mcause=2, mepc=0x500, redirect to mtvec base.
- exceptionE, iretE, irqExt and csrWe to mtvec all in one cycle -> exception taken, mtvec unchanged; redirectReady held 0 for 3 cycles -> redirectValid/busy/redirectPC stable for those cycles, and new exceptions in that window are ignored.
- Assert rst_n=0 while in REDIRECT -> next cycle redirectValid=0, busy=0, mtvec=RESET_TVEC.

Source files
------------

// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap entry/return for the execute stage.
// It holds mstatus/mtvec/mepc/mcause and the privilege level. It issues one
// registered PC redirect plus flush, then holds it until fetch accepts.
module trap_controller #(
  parameter logic [31:0] RESET_TVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exceptionE,
  input  logic [7:0]  exceptionCodeE,
  input  logic        iretE,
  input  logic [1:0]  retKindE,
  input  logic [31:0] pcE,
  input  logic        irqExt,
  input  logic        csrWe,
  input  logic [11:0] csrAddr,
  input  logic [31:0] csrWData,
  output logic [31:0] csrRData,
  output logic        redirectValid,
  input  logic        redirectReady,
  output logic [31:0] redirectPC,
  output logic        flush,
  output logic        busy,
  output logic [1:0]  privMode
);

  typedef enum logic {IDLE, REDIRECT} state_e;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [1:0]  PRIV_M       = 2'b11;
  localparam logic [1:0]  PRIV_U       = 2'b00;
  localparam logic [31:0] IRQ_CAUSE    = 32'h8000_000B;
  localparam logic [31:0] IRQ_VEC_OFS  = 32'h0000_002C;
  localparam logic [7:0]  ILLEGAL_CODE = 8'd2;

  state_e      state_q, state_d;
  logic [1:0]  priv_q, priv_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [1:0]  mpp_q, mpp_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        bad_ret;
  logic        exc_sel;
  logic        mret_sel;
  logic        irq_sel;
  logic [7:0]  exc_code;
  logic [31:0] tvec_base;

  // Event priority: exception (including unsupported xRET) > mret > interrupt.
  always_comb begin
    bad_ret   = iretE && (retKindE != 2'b11);
    exc_sel   = exceptionE || bad_ret;
    mret_sel  = !exc_sel && iretE;
    irq_sel   = !exc_sel && !iretE && irqExt && mie_q;
    exc_code  = exceptionE ? exceptionCodeE : ILLEGAL_CODE;
    tvec_base = {mtvec_q[31:2], 2'b00};
  end

  // Next-state, CSR update and redirect generation.
  // NOTE: every *_d gets its _q value first so no path through this block can infer a latch.
  always_comb begin
    state_d          = state_q;
    priv_d           = priv_q;
    mie_d            = mie_q;
    mpie_d           = mpie_q;
    mpp_d            = mpp_q;
    mtvec_d          = mtvec_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;

    case (state_q)
      IDLE: begin
        if (exc_sel || irq_sel) begin
          mepc_d           = pcE & 32'hFFFF_FFFC;
          mcause_d         = irq_sel ? IRQ_CAUSE : {24'b0, exc_code};
          mpie_d           = mie_q;
          mie_d            = 1'b0;
          mpp_d            = priv_q;
          priv_d           = PRIV_M;
          redirect_pc_d    = (irq_sel && mtvec_q[0]) ? tvec_base + IRQ_VEC_OFS : tvec_base;
          redirect_valid_d = 1'b1;
          state_d          = REDIRECT;
        end else if (mret_sel) begin
          priv_d           = mpp_q;
          mie_d            = mpie_q;
          mpie_d           = 1'b1;
          mpp_d            = PRIV_U;
          redirect_pc_d    = mepc_q;
          redirect_valid_d = 1'b1;
          state_d          = REDIRECT;
        end else if (csrWe) begin
          // Software CSR writes land only on cycles with no trap or return.
          case (csrAddr)
            ADDR_MSTATUS: begin
              mie_d  = csrWData[3];
              mpie_d = csrWData[7];
              mpp_d  = (csrWData[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
            end
            ADDR_MTVEC:  mtvec_d  = csrWData;
            ADDR_MEPC:   mepc_d   = csrWData & 32'hFFFF_FFFC;
            ADDR_MCAUSE: mcause_d = csrWData;
            default: ;
          endcase
        end
      end
      REDIRECT: begin
        if (redirectReady) begin
          redirect_valid_d = 1'b0;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      priv_q           <= PRIV_M;
      mie_q            <= 1'b0;
      mpie_q           <= 1'b0;
      mpp_q            <= PRIV_U;
      mtvec_q          <= RESET_TVEC;
      mepc_q           <= 32'h0;
      mcause_q         <= 32'h0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
    end else begin
      state_q          <= state_d;
      priv_q           <= priv_d;
      mie_q            <= mie_d;
      mpie_q           <= mpie_d;
      mpp_q            <= mpp_d;
      mtvec_q          <= mtvec_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  // CSR read port shows pre-edge register state; unmapped addresses read zero.
  always_comb begin
    csrRData = 32'h0;
    case (csrAddr)
      ADDR_MSTATUS: csrRData = {19'b0, mpp_q, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
      ADDR_MTVEC:   csrRData = mtvec_q;
      ADDR_MEPC:    csrRData = mepc_q;
      ADDR_MCAUSE:  csrRData = mcause_q;
      default:      csrRData = 32'h0;
    endcase
  end

  // Redirect, flush and stall are all asserted exactly while REDIRECT is held.
  assign redirectValid = redirect_valid_q;
  assign flush         = redirect_valid_q;
  assign busy          = redirect_valid_q;
  assign redirectPC    = redirect_pc_q;
  assign privMode      = priv_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed, table-driven bench for trap_controller.
module tb_trap_controller;

  logic        clk;
  logic        rst_n;
  logic        exceptionE;
  logic [7:0]  exceptionCodeE;
  logic        iretE;
  logic [1:0]  retKindE;
  logic [31:0] pcE;
  logic        irqExt;
  logic        csrWe;
  logic [11:0] csrAddr;
  logic [31:0] csrWData;
  logic [31:0] csrRData;
  logic        redirectValid;
  logic        redirectReady;
  logic [31:0] redirectPC;
  logic        flush;
  logic        busy;
  logic [1:0]  privMode;

  int n_vec = 0;
  int n_bad = 0;

  trap_controller #(.RESET_TVEC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exceptionE     (exceptionE),
    .exceptionCodeE (exceptionCodeE),
    .iretE          (iretE),
    .retKindE       (retKindE),
    .pcE            (pcE),
    .irqExt         (irqExt),
    .csrWe          (csrWe),
    .csrAddr        (csrAddr),
    .csrWData       (csrWData),
    .csrRData       (csrRData),
    .redirectValid  (redirectValid),
    .redirectReady  (redirectReady),
    .redirectPC     (redirectPC),
    .flush          (flush),
    .busy           (busy),
    .privMode       (privMode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        exc;
    logic [7:0]  code;
    logic        iret;
    logic [1:0]  kind;
    logic [31:0] pc;
    logic        irq;
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        ready;
    logic [11:0] raddr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [1:0]  exp_priv;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic exc, input logic [7:0] code, input logic iret, input logic [1:0] kind,
    input logic [31:0] pc, input logic irq, input logic we, input logic [11:0] waddr,
    input logic [31:0] wdata, input logic ready, input logic [11:0] raddr,
    input logic exp_valid, input logic [31:0] exp_pc, input logic [1:0] exp_priv,
    input logic [31:0] exp_rdata);
    vec_t v;
    v.exc = exc; v.code = code; v.iret = iret; v.kind = kind; v.pc = pc; v.irq = irq;
    v.we = we; v.waddr = waddr; v.wdata = wdata; v.ready = ready; v.raddr = raddr;
    v.exp_valid = exp_valid; v.exp_pc = exp_pc; v.exp_priv = exp_priv; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    exceptionE     = 1'b0;
    exceptionCodeE = 8'h0;
    iretE          = 1'b0;
    retKindE       = 2'b00;
    pcE            = 32'h0;
    irqExt         = 1'b0;
    csrWe          = 1'b0;
    csrWData       = 32'h0;
    redirectReady  = 1'b0;
  endtask

  // Drive one cycle of inputs, clock it, then compare the post-edge outputs.
  task automatic apply_vec(input string tag, input vec_t v);
    exceptionE     = v.exc;
    exceptionCodeE = v.code;
    iretE          = v.iret;
    retKindE       = v.kind;
    pcE            = v.pc;
    irqExt         = v.irq;
    csrWe          = v.we;
    csrAddr        = v.waddr;
    csrWData       = v.wdata;
    redirectReady  = v.ready;
    @(posedge clk);
    #1;
    idle_inputs();
    csrAddr = v.raddr;
    #1;
    check({tag, " valid"}, 32'(redirectValid), 32'(v.exp_valid));
    check({tag, " flush"}, 32'(flush), 32'(v.exp_valid));
    check({tag, " busy"},  32'(busy), 32'(v.exp_valid));
    if (v.exp_valid) check({tag, " pc"}, redirectPC, v.exp_pc);
    check({tag, " priv"},  32'(privMode), 32'(v.exp_priv));
    check($sformatf("%s csr%h", tag, v.raddr), csrRData, v.exp_rdata);
  endtask

  task automatic read_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
    csrAddr = a;
    #1;
    check(name, csrRData, exp);
  endtask

  initial begin
    // Main vector table: each row is one cycle of inputs and the state seen after its edge.
    //            exc code  iret kind pc            irq we waddr  wdata         rdy raddr  val pc            priv   rdata
    vecs.push_back(mk(1, 8'h02, 0, 2'b00, 32'h2004, 0, 0, 12'h0,  32'h0,        0, 12'h342, 1, 32'h100, 2'b11, 32'h2));
    vecs.push_back(mk(0, 8'h00, 0, 2'b00, 32'h0,    0, 0, 12'h0,  32'h0,        1, 12'h341, 0, 32'h0,   2'b11, 32'h2004));
    vecs.push_back(mk(0, 8'h00, 0, 2'b00, 32'h0,    0, 1, 12'h300, 32'h8,       0, 12'h300, 0, 32'h0,   2'b11, 32'h8));
    vecs.push_back(mk(0, 8'h00, 0, 2'b00, 32'h0,    0, 1, 12'h305, 32'h401,     0, 12'h305, 0, 32'h0,   2'b11, 32'h401));
    vecs.push_back(mk(0, 8'h00, 0, 2'b00, 32'h3000, 1, 0, 12'h0,  32'h0,        0, 12'h342, 1, 32'h42C, 2'b11, 32'h8000_000B));
    vecs.push_back(mk(0, 8'h00, 0, 2'b00, 32'h3000, 1, 0, 12'h0,  32'h0,        0, 12'h300, 1, 32'h42C, 2'b11, 32'h1880));
    vecs.push_back(mk(0, 8'h00, 0, 2'b00, 32'h3000, 1, 0, 12'h0,  32'h0,        1, 12'h341, 0, 32'h0,   2'b11, 32'h3000));
    vecs.push_back(mk(0, 8'h00, 0, 2'b00, 32'h3100, 1, 0, 12'h0,  32'h0,        0, 12'h300, 0, 32'h0,   2'b11, 32'h1880));
    vecs.push_back(mk(0, 8'h00, 0, 2'b00, 32'h0,    0, 1, 12'h300, 32'h881,     0, 12'h300, 0, 32'h0,   2'b11, 32'h80));
    vecs.push_back(mk(0, 8'h00, 1, 2'b11, 32'h3010, 0, 0, 12'h0,  32'h0,        0, 12'h300, 1, 32'h3000, 2'b00, 32'h88));
    vecs.push_back(mk(0, 8'h00, 0, 2'b00, 32'h0,    0, 0, 12'h0,  32'h0,        1, 12'h300, 0, 32'h0,   2'b00, 32'h88));
    vecs.push_back(mk(1, 8'h08, 0, 2'b00, 32'h4000, 0, 0, 12'h0,  32'h0,        1, 12'h300, 1, 32'h400, 2'b11, 32'h80));
    vecs.push_back(mk(0, 8'h00, 0, 2'b00, 32'h0,    0, 0, 12'h0,  32'h0,        1, 12'h342, 0, 32'h0,   2'b11, 32'h8));
    vecs.push_back(mk(0, 8'h00, 1, 2'b11, 32'h4004, 0, 0, 12'h0,  32'h0,        0, 12'h300, 1, 32'h4000, 2'b00, 32'h88));
    vecs.push_back(mk(0, 8'h00, 0, 2'b00, 32'h0,    0, 0, 12'h0,  32'h0,        1, 12'h300, 0, 32'h0,   2'b00, 32'h88));
    vecs.push_back(mk(0, 8'h00, 1, 2'b01, 32'h500,  0, 0, 12'h0,  32'h0,        0, 12'h342, 1, 32'h400, 2'b11, 32'h2));
    vecs.push_back(mk(0, 8'h00, 0, 2'b00, 32'h0,    0, 0, 12'h0,  32'h0,        1, 12'h341, 0, 32'h0,   2'b11, 32'h500));
    vecs.push_back(mk(0, 8'h00, 1, 2'b00, 32'h600,  0, 0, 12'h0,  32'h0,        0, 12'h342, 1, 32'h400, 2'b11, 32'h2));
    vecs.push_back(mk(0, 8'h00, 0, 2'b00, 32'h0,    0, 0, 12'h0,  32'h0,        1, 12'h300, 0, 32'h0,   2'b11, 32'h1800));
    // Every event plus an mtvec write at once; then three stalled cycles with ignored events/writes.
    vecs.push_back(mk(1, 8'h0D, 1, 2'b11, 32'h700,  1, 1, 12'h305, 32'hDEAD_0000, 0, 12'h305, 1, 32'h400, 2'b11, 32'h401));
    vecs.push_back(mk(1, 8'h03, 0, 2'b00, 32'h900,  0, 1, 12'h342, 32'h55,      0, 12'h342, 1, 32'h400, 2'b11, 32'h0D));
    vecs.push_back(mk(1, 8'h03, 1, 2'b11, 32'h904,  1, 1, 12'h342, 32'h55,      0, 12'h342, 1, 32'h400, 2'b11, 32'h0D));
    vecs.push_back(mk(1, 8'h03, 0, 2'b00, 32'h908,  0, 1, 12'h305, 32'h55,      0, 12'h341, 1, 32'h400, 2'b11, 32'h700));
    vecs.push_back(mk(0, 8'h00, 0, 2'b00, 32'h0,    0, 0, 12'h0,  32'h0,        1, 12'h341, 0, 32'h0,   2'b11, 32'h700));
    // Back-to-back: exception in the first IDLE cycle after the handshake.
    vecs.push_back(mk(1, 8'h04, 0, 2'b00, 32'hA00,  0, 0, 12'h0,  32'h0,        0, 12'h342, 1, 32'h400, 2'b11, 32'h4));
    vecs.push_back(mk(0, 8'h00, 0, 2'b00, 32'h0,    0, 1, 12'h305, 32'h888,     1, 12'h305, 0, 32'h0,   2'b11, 32'h401));
    vecs.push_back(mk(0, 8'h00, 0, 2'b00, 32'h0,    0, 1, 12'h123, 32'hFFFF,    0, 12'h123, 0, 32'h0,   2'b11, 32'h0));
    vecs.push_back(mk(0, 8'h00, 0, 2'b00, 32'h0,    0, 1, 12'h341, 32'h1237,    0, 12'h341, 0, 32'h0,   2'b11, 32'h1234));

    // Reset and its state.
    idle_inputs();
    csrAddr = 12'h0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst valid", 32'(redirectValid), 32'h0);
    check("rst flush", 32'(flush), 32'h0);
    check("rst busy",  32'(busy), 32'h0);
    check("rst pc",    redirectPC, 32'h0);
    check("rst priv",  32'(privMode), 32'h3);
    read_csr("rst mtvec",   12'h305, 32'h100);
    read_csr("rst mstatus", 12'h300, 32'h0);
    read_csr("rst mepc",    12'h341, 32'h0);
    read_csr("rst mcause",  12'h342, 32'h0);

    foreach (vecs[i]) apply_vec($sformatf("vec%0d", i), vecs[i]);

    // Reset while a redirect is pending aborts it on the same edge.
    apply_vec("rstmid enter", mk(1, 8'h01, 0, 2'b00, 32'hB00, 0, 0, 12'h0, 32'h0, 0, 12'h342, 1, 32'h400, 2'b11, 32'h1));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rstmid valid", 32'(redirectValid), 32'h0);
    check("rstmid busy",  32'(busy), 32'h0);
    check("rstmid flush", 32'(flush), 32'h0);
    check("rstmid pc",    redirectPC, 32'h0);
    check("rstmid priv",  32'(privMode), 32'h3);
    read_csr("rstmid mtvec", 12'h305, 32'h100);

    // Direct-mode interrupt goes to the base of mtvec.
    apply_vec("irqd mie",  mk(0, 8'h00, 0, 2'b00, 32'h0,   0, 1, 12'h300, 32'h8, 0, 12'h300, 0, 32'h0,   2'b11, 32'h8));
    apply_vec("irqd take", mk(0, 8'h00, 0, 2'b00, 32'hC00, 1, 0, 12'h0,   32'h0, 0, 12'h342, 1, 32'h100, 2'b11, 32'h8000_000B));
    apply_vec("irqd done", mk(0, 8'h00, 0, 2'b00, 32'h0,   0, 0, 12'h0,   32'h0, 1, 12'h341, 0, 32'h0,   2'b11, 32'hC00));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
